// File: rtl/platform_pkg.sv
// Shared types and sizes for the platform line renderer.
// Holds the table depth, sprite dimensions, scan FSM states and line-buffer entry layout.
package platform_pkg;

   localparam int NUM_PLAT = 8;
   localparam int PLAT_W   = 16;
   localparam int PLAT_H   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef struct packed {
      logic              hit;
      logic [9:0]        x;
      logic [PLAT_W-1:0] row;
   } line_ent_t;

endpackage

// File: rtl/platform_renderer_if.sv
// Table-write, scanline, sprite-ROM and pixel signals of the platform renderer.
// The master side drives the table, the scan timing and the ROM data; the slave is the renderer.
interface platform_renderer_if;

   logic        we;
   logic [2:0]  wr_idx;
   logic [9:0]  wr_x;
   logic [9:0]  wr_y;
   logic        wr_valid;
   logic        line_start;
   logic [9:0]  line_y;
   logic [9:0]  DrawX;
   logic [10:0] sprite_addr;
   logic [15:0] sprite_data;
   logic        pixel_on;
   logic        busy;

   modport master (
      output we, wr_idx, wr_x, wr_y, wr_valid, line_start, line_y, DrawX, sprite_data,
      input  sprite_addr, pixel_on, busy
   );

   modport slave (
      input  we, wr_idx, wr_x, wr_y, wr_valid, line_start, line_y, DrawX, sprite_data,
      output sprite_addr, pixel_on, busy
   );

endinterface

// File: rtl/platform_table.sv
// Platform position table: one synchronous write port, one combinational read port.
// A read in the same cycle as a write to that entry returns the pre-write contents.
module platform_table #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          i_we,
   input  logic [2:0]    i_wr_idx,
   input  logic [9:0]    i_wr_x,
   input  logic [9:0]    i_wr_y,
   input  logic          i_wr_valid,
   input  logic [IW-1:0] i_rd_idx,
   output logic [9:0]    o_rd_x,
   output logic [9:0]    o_rd_y,
   output logic          o_rd_valid
);

   logic [9:0] r_x     [N];
   logic [9:0] r_y     [N];
   logic       r_valid [N];
   logic       w_wr_ok;

   assign w_wr_ok = i_we && (32'(i_wr_idx) < N);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 0; k < N; k++) r_valid[k] <= 1'b0;
      end else if (w_wr_ok) begin
         r_valid[i_wr_idx] <= i_wr_valid;
      end
   end

   // Coordinates need no reset: they are ignored while the valid bit is clear.
   always_ff @(posedge Clk) begin
      if (!Reset && w_wr_ok) begin
         r_x[i_wr_idx] <= i_wr_x;
         r_y[i_wr_idx] <= i_wr_y;
      end
   end

   assign o_rd_x     = r_x[i_rd_idx];
   assign o_rd_y     = r_y[i_rd_idx];
   assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/platform_renderer.sv
// Prefetches each platform's sprite row into a shadow line buffer during an NUM_PLAT-cycle scan.
// pixel_on is the registered OR of all active-bank hits, one cycle after DrawX.
module platform_renderer
   import platform_pkg::*;
#(
   parameter int          NUM_PLAT = platform_pkg::NUM_PLAT,
   parameter logic [10:0] ROW_BASE = 11'd0
) (
   input logic                Clk,
   input logic                Reset,
   platform_renderer_if.slave bus
);

   localparam int IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_idx;
   logic [9:0]    r_tgt;
   logic          r_act;
   line_ent_t     r_bank [2][NUM_PLAT];
   logic          r_pixel_on;

   logic          w_busy;
   logic          w_last;
   logic [9:0]    w_rd_x;
   logic [9:0]    w_rd_y;
   logic          w_rd_valid;
   logic [9:0]    w_d;
   logic          w_scan_hit;
   logic [9:0]    w_off [NUM_PLAT];
   logic          w_pix;

   platform_table #(.N(NUM_PLAT), .IW(IW)) u_table (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_we       (bus.we),
      .i_wr_idx   (bus.wr_idx),
      .i_wr_x     (bus.wr_x),
      .i_wr_y     (bus.wr_y),
      .i_wr_valid (bus.wr_valid),
      .i_rd_idx   (r_idx),
      .o_rd_x     (w_rd_x),
      .o_rd_y     (w_rd_y),
      .o_rd_valid (w_rd_valid)
   );

   assign w_last     = (r_idx == IW'(NUM_PLAT - 1));
   assign w_d        = r_tgt - w_rd_y;
   assign w_scan_hit = (r_state == SCAN) && w_rd_valid && (w_d < 10'(PLAT_H));

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.line_start) w_state_nxt = SCAN;
         end
         SCAN: begin
            w_busy = 1'b1;
            if (!bus.line_start && w_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A new line_start always wins over an in-flight scan: the partial shadow becomes active.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_idx <= '0;
         r_tgt <= '0;
         r_act <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < NUM_PLAT; k++) r_bank[b][k].hit <= 1'b0;
      end else if (bus.line_start) begin
         r_act <= !r_act;
         r_tgt <= bus.line_y;
         r_idx <= '0;
         for (int k = 0; k < NUM_PLAT; k++) r_bank[r_act][k].hit <= 1'b0;
      end else if (r_state == SCAN) begin
         if (w_scan_hit) r_bank[!r_act][r_idx] <= '{hit: 1'b1, x: w_rd_x, row: bus.sprite_data};
         r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
   end

   always_comb begin
      w_pix = 1'b0;
      for (int k = 0; k < NUM_PLAT; k++) begin
         w_off[k] = bus.DrawX - r_bank[r_act][k].x;
         if (r_bank[r_act][k].hit && (w_off[k] < 10'(PLAT_W)) &&
             r_bank[r_act][k].row[4'd15 - w_off[k][3:0]])
            w_pix = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) r_pixel_on <= 1'b0;
      else       r_pixel_on <= w_pix;
   end

   assign bus.sprite_addr = w_scan_hit ? (ROW_BASE + {9'd0, w_d[1:0]}) : ROW_BASE;
   assign bus.pixel_on    = r_pixel_on;
   assign bus.busy        = w_busy;

endmodule

// File: tb/tb_platform_renderer.sv
// Scoreboard bench for platform_renderer: expected pixels queued when DrawX is driven, popped a cycle later.
module tb_platform_renderer;

   localparam logic [10:0] RB = 11'd32;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   platform_renderer_if bus ();

   platform_renderer #(.NUM_PLAT(8), .ROW_BASE(RB)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [15:0] rom [0:2047];
   assign bus.sprite_data = rom[bus.sprite_addr];

   logic [9:0] m_x [8];
   logic [9:0] m_y [8];
   bit         m_v [8];
   logic       sb  [$];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_pix(input logic [9:0] c, input logic [9:0] tgt);
      logic [9:0]  d;
      logic [9:0]  o;
      logic [15:0] row;
      int          b;
      model_pix = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (m_v[k]) begin
            d = tgt - m_y[k];
            o = c - m_x[k];
            if (d < 10'd4 && o < 10'd16) begin
               row = rom[RB + {1'b0, d}];
               b   = 15 - int'(o);
               if (row[b]) model_pix = 1'b1;
            end
         end
      end
   endfunction

   task automatic wr(input int idx, input int x, input int y, input bit v);
      @(negedge Clk);
      bus.we = 1'b1; bus.wr_idx = idx[2:0]; bus.wr_x = x[9:0]; bus.wr_y = y[9:0]; bus.wr_valid = v;
      @(negedge Clk);
      bus.we = 1'b0;
      m_x[idx] = x[9:0]; m_y[idx] = y[9:0]; m_v[idx] = v;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 40) begin
         @(negedge Clk);
         n++;
      end
      if (bus.busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic start_line(input logic [9:0] y);
      @(negedge Clk);
      bus.line_start = 1'b1; bus.line_y = y;
      @(negedge Clk);
      bus.line_start = 1'b0;
      wait_idle();
   endtask

   // First scan fills the shadow, second swaps it to active.
   task automatic new_line(input logic [9:0] y);
      start_line(y);
      start_line(y);
   endtask

   task automatic pix_at(input string tag, input int c, input logic exp);
      @(negedge Clk);
      bus.DrawX = c[9:0];
      sb.push_back(exp);
      @(negedge Clk);
      chk(tag, bus.pixel_on, sb.pop_front());
   endtask

   task automatic sweep(input logic [9:0] tgt);
      for (int c = 0; c <= 1024; c++) begin
         @(negedge Clk);
         if (c > 0) chk("sweep", bus.pixel_on, sb.pop_front());
         if (c < 1024) begin
            bus.DrawX = c[9:0];
            sb.push_back(model_pix(c[9:0], tgt));
         end
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
   endtask

   initial begin
      int n;
      int m;
      for (int a = 0; a < 2048; a++) rom[a] = 16'h0000;
      rom[RB + 11'd0] = 16'hF000;
      rom[RB + 11'd1] = 16'h8001;
      rom[RB + 11'd2] = 16'hFFFF;
      rom[RB + 11'd3] = 16'h00FF;
      for (int k = 0; k < 8; k++) begin m_x[k] = '0; m_y[k] = '0; m_v[k] = 1'b0; end
      Reset = 1'b1;
      bus.we = 1'b0; bus.wr_idx = '0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_valid = 1'b0;
      bus.line_start = 1'b0; bus.line_y = '0; bus.DrawX = '0;
      do_reset();

      // Reset state
      @(negedge Clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_pix", bus.pixel_on, 0);
      chk("rst_addr", bus.sprite_addr, RB);

      // Row 1 hit, ends of the 16-pixel span
      wr(0, 100, 200, 1'b1);
      @(negedge Clk);
      bus.line_start = 1'b1; bus.line_y = 10'd201;
      @(negedge Clk);
      chk("scan_busy", bus.busy, 1);
      chk("sa_row1", bus.sprite_addr, RB + 11'd1);
      bus.line_start = 1'b0;
      wait_idle();
      chk("idle_addr", bus.sprite_addr, RB);
      start_line(10'd201);
      pix_at("px99", 99, 1'b0);
      pix_at("px100", 100, 1'b1);
      pix_at("px101", 101, 1'b0);
      pix_at("px115", 115, 1'b1);
      pix_at("px116", 116, 1'b0);
      sweep(10'd201);

      // Just below and above the platform
      new_line(10'd204);
      pix_at("miss204", 100, 1'b0);
      sweep(10'd204);
      new_line(10'd199);
      pix_at("miss199", 100, 1'b0);
      sweep(10'd199);

      // Scan length and restart
      @(negedge Clk);
      bus.line_start = 1'b1; bus.line_y = 10'd5;
      @(negedge Clk);
      bus.line_start = 1'b0;
      n = 0;
      while (bus.busy && n < 40) begin n++; @(negedge Clk); end
      chk("busy_len", n, 8);
      @(negedge Clk);
      bus.line_start = 1'b1;
      @(negedge Clk);
      bus.line_start = 1'b0;
      n = 0;
      repeat (2) begin if (bus.busy) n++; @(negedge Clk); end
      if (bus.busy) n++;
      bus.line_start = 1'b1;
      @(negedge Clk);
      bus.line_start = 1'b0;
      m = 0;
      while (bus.busy && m < 40) begin m++; @(negedge Clk); end
      chk("busy_pre", n, 3);
      chk("busy_restart", m, 8);
      chk("busy_done", bus.busy, 0);

      // Write collides with the scan read of the same entry
      @(negedge Clk);
      bus.line_start = 1'b1; bus.line_y = 10'd200;
      @(negedge Clk);
      chk("sa_row0", bus.sprite_addr, RB);
      bus.line_start = 1'b0;
      bus.we = 1'b1; bus.wr_idx = 3'd0; bus.wr_x = 10'd100; bus.wr_y = 10'd300; bus.wr_valid = 1'b1;
      @(negedge Clk);
      bus.we = 1'b0;
      wait_idle();
      start_line(10'd200);
      pix_at("old_y_hit", 103, 1'b1);
      sweep(10'd200);
      m_y[0] = 10'd300;
      start_line(10'd200);
      pix_at("new_y_miss", 100, 1'b0);

      // Reset in the middle of a scan
      wr(0, 100, 200, 1'b1);
      new_line(10'd200);
      pix_at("pre_rst_pix", 100, 1'b1);
      @(negedge Clk);
      bus.line_start = 1'b1;
      @(negedge Clk);
      bus.line_start = 1'b0;
      repeat (2) @(negedge Clk);
      chk("mid_scan_busy", bus.busy, 1);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_pix", bus.pixel_on, 0);
      Reset = 1'b0;
      for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
      new_line(10'd200);
      pix_at("rst_invalid", 100, 1'b0);
      sweep(10'd200);

      // Overlap and right-edge wrap
      wr(0, 50, 10, 1'b1);
      wr(1, 58, 10, 1'b1);
      wr(2, 1016, 10, 1'b1);
      new_line(10'd12);
      pix_at("ovl49", 49, 1'b0);
      for (int c = 50; c <= 73; c++) pix_at("ovl_run", c, 1'b1);
      pix_at("ovl74", 74, 1'b0);
      pix_at("wrap1023", 1023, 1'b1);
      pix_at("wrap3", 3, 1'b1);
      pix_at("wrap8", 8, 1'b0);
      sweep(10'd12);

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/platform_renderer.md
PLATFORM_RENDERER -- requirements
Module: platform_renderer

Interface
REQ-001 SHALL have parameter NUM_PLAT, default 8, number of platform table entries.
REQ-002 SHALL have parameter ROW_BASE, default 11'd0, sprite ROM address of platform row 0.
REQ-003 SHALL have one clock and a synchronous, active-high reset: Clk input 1, rising-edge clock; Reset input 1, synchronous active-high reset.
REQ-004 SHALL have port we, input, 1 bit: table write strobe.
REQ-005 SHALL have port wr_idx, input, 3 bits: table entry index.
REQ-006 SHALL have port wr_x, input, 10 bits: platform left column.
REQ-007 SHALL have port wr_y, input, 10 bits: platform top row.
REQ-008 SHALL have port wr_valid, input, 1 bit: entry enable.
REQ-009 SHALL have port line_start, input, 1 bit: one-cycle pulse at the start of each scanline.
REQ-010 SHALL have port line_y, input, 10 bits: scanline to prefetch, sampled on line_start.
REQ-011 SHALL have port DrawX, input, 10 bits: current pixel column.
REQ-012 SHALL have port sprite_addr, output, 11 bits: address to the combinational platform sprite ROM.
REQ-013 SHALL have port sprite_data, input, 16 bits: ROM row; bit 15 is the leftmost pixel.
REQ-014 SHALL have port pixel_on, output, 1 bit: platform pixel present at DrawX.
REQ-015 SHALL have port busy, output, 1 bit: scan in progress.

Function
REQ-016 SHALL hold a table of NUM_PLAT entries {x[9:0], y[9:0], valid}; a write with we=1 updates entry wr_idx at the clock edge.
REQ-017 SHALL keep two line-buffer banks, active and shadow; each bank holds per entry {hit, x, row[15:0]}.
REQ-018 On line_start, SHALL swap the active and shadow banks, latch line_y into tgt, clear all shadow hit flags, set entry counter i=0, and enter SCAN.
REQ-019 SHALL use FSM states IDLE and SCAN; SCAN -> IDLE after entry NUM_PLAT-1 is processed, so a scan lasts exactly NUM_PLAT cycles; busy=1 only in SCAN.
REQ-020 In SCAN, for entry i, SHALL compute d = tgt - y[i] as 10-bit unsigned; if valid[i] and d<4, then sprite_addr = ROW_BASE + d[1:0], shadow.hit[i]=1, shadow.x[i]=x[i], and shadow.row[i]=sprite_data on that cycle; otherwise the shadow hit flag stays 0.
REQ-021 Outside SCAN, sprite_addr SHALL be ROW_BASE.
REQ-022 If a table write and a scan read hit the same entry in the same cycle, the scan SHALL use the pre-write value.
REQ-023 A line_start during SCAN SHALL abort the scan, perform the swap and restart at i=0; the partially filled bank becomes active.
REQ-024 Per pixel, SHALL compute o = DrawX - active.x[i] (10-bit unsigned); the entry contributes when hit[i] and o<16 and row[i][15-o]=1.
REQ-025 pixel_on SHALL be the registered OR over all entries, giving 1-cycle latency from DrawX.
REQ-026 For platforms at x>1008, columns past 1023 SHALL wrap; the module SHALL NOT clip them.
REQ-027 Overlapping platforms SHALL simply OR their pixels.

Reset
REQ-028 Reset SHALL clear all valid bits, both banks' hit flags and tgt, and set the FSM to IDLE, i=0, pixel_on=0, busy=0.
REQ-029 Reset SHALL take priority over line_start and we in the same cycle; a reset mid-scan SHALL discard the scan.

Structure
REQ-030 Package platform_pkg SHALL hold NUM_PLAT, PLAT_W=16, PLAT_H=4, the state enum {IDLE, SCAN}, and the line-buffer entry struct.
REQ-031 The platform table SHALL be one sub-module, platform_table, with one write port and one read port.
REQ-032 The sprite ROM SHALL stay external and be connected through sprite_addr and sprite_data.

Verification
REQ-033 Entry0 {x=100, y=200, valid}, line_start with line_y=201, ROM row1=16'h8001, then a second line_start: pixel_on=1 at DrawX 100 and 115 only (one cycle later); 0 at 99, 101 and 116.
REQ-034 Same entry, line_y=204 or 199: no hit, and pixel_on stays 0 across the whole line.
REQ-035 line_start: busy is high for exactly 8 cycles; a second line_start at cycle 3 restarts the count, and busy stays high 8 more cycles.
REQ-036 Write entry0 y=300 in the cycle the scan reads entry0 with line_y=200 and old y=200: hit uses the old y, giving a row0 hit.
REQ-037 Reset asserted in cycle 4 of a scan: busy=0 and pixel_on=0 next cycle, and all entries are invalid.
REQ-038 Entries 0 and 1 at x=50 and x=58, both on the line with row=16'hFFFF: pixel_on=1 for DrawX 50..73 contiguous.
